board_probe_ctrl: RTL and testbench
===================================

# board_probe_ctrl

Synchronous front-panel controller that turns raw board switches and push-buttons into clean, single-cycle control for a device under test (register file, ALU, shifter) and selects which DUT value appears on the seven-segment display. It replaces per-button clocking with one-clock debounced edge detection, and generalises the panel to N load slots, M view channels and a free-running auto-step mode. It sits between the board pins and the DUT, and feeds `Display` via `disp_data`.

## Interface
- `SW_W`, 32: switch bank width, and width of each load slot.
- `NUM_LOAD`, 4: number of load slots (≥2).
- `NUM_VIEW`, 8: number of display channels (≥2).
- `DB_CYCLES`, 500000: debounce stability window in `clk` cycles (≥2).
- `RUN_PERIOD`, 50000000: auto-step period in cycles (≥2).
- `clk` in 1: board clock. Only clock in the block.
- `rst` in 1: synchronous, active-high reset.
- `sw` in SW_W: raw switch bank.
- `btn_next`, `btn_load`, `btn_view`, `btn_step`, `btn_run` in 1 each: raw asynchronous push-buttons.
- `view_data` in NUM_VIEW*32: flattened DUT observation words; channel i is `[32*i+31:32*i]`.
- `load_bus` out NUM_LOAD*SW_W: flattened slot registers; slot i is `[SW_W*i+SW_W-1:SW_W*i]`.
- `load_strobe` out NUM_LOAD: one-hot, one-cycle pulse when a slot is written.
- `step_pulse` out 1: one-cycle DUT clock-enable.
- `disp_data` out 32: registered selected view word.
- `load_idx` out clog2(NUM_LOAD): current load slot.
- `view_idx` out clog2(NUM_VIEW): current view channel.
- `run_mode` out 1: 1 while auto-step is active.

## Operation
- Button conditioning, identical per button: 2-flop synchroniser, then a debouncer with a `stable` level and a counter. When the synchronised input ≠ `stable`, the counter increments. When it ≠ `stable` for DB_CYCLES consecutive cycles, `stable` takes the new level. Any return to `stable` level clears the counter. An internal pulse is asserted for one cycle on each `stable` 0→1. Release (1→0) produces no pulse.
- `btn_next`: `load_idx` ← (`load_idx`+1) mod NUM_LOAD.
- `btn_load`: slot[`load_idx`] ← `sw`, and `load_strobe[load_idx]` pulses in the same cycle the slot updates.
- `btn_view`: `view_idx` ← (`view_idx`+1) mod NUM_VIEW.
- `disp_data` ← `view_data` channel `view_idx`, registered every cycle. It tracks live DUT changes, not only button events.
- Step FSM, states IDLE and RUN:
  - IDLE: the `btn_step` pulse drives `step_pulse` for one cycle. The `btn_run` pulse moves to RUN and clears the period counter.
  - RUN: the period counter counts 0..RUN_PERIOD-1 and wraps. `step_pulse` is asserted when the counter = RUN_PERIOD-1. `btn_step` is ignored. The `btn_run` pulse moves to IDLE, with no `step_pulse` in that cycle.
  - `run_mode` = (state == RUN).
- Simultaneous pulses:
  - `btn_load` and `btn_next` together: the load uses the old `load_idx`, and the index advances in the same edge.
  - `btn_step` and `btn_run` in IDLE: the step is issued and the state goes to RUN.
  - All buttons are independent otherwise.

## Timing
- Reset values, applied on the `rst`-high edge:
  - Outputs: all slots 0, `load_strobe` 0, `step_pulse` 0, `disp_data` 0, `load_idx` 0, `view_idx` 0, `run_mode` 0.
  - Internal: state IDLE; synchronisers, debounce levels and counters all 0.
- `rst` asserted mid-debounce or mid-RUN aborts everything. A button held through reset release must be seen stable for DB_CYCLES again before it produces a pulse.
- Button latency: the raw input rises before edge 0 and stays high. The internal pulse is high for the cycle after edge DB_CYCLES+2. Effects appear at edge DB_CYCLES+3: index change, slot write with strobe, or `step_pulse` high for that one cycle.
- A glitch shorter than DB_CYCLES cycles produces no pulse. There is at most one pulse per press.
- `disp_data` lags `view_idx` / `view_data` by exactly 1 cycle.
- RUN: the first `step_pulse` is RUN_PERIOD cycles after the RUN entry edge, then every RUN_PERIOD cycles.
- Index wrap: from NUM_LOAD-1 to 0, and from NUM_VIEW-1 to 0.

## Test plan
Parameters for the bench: DB_CYCLES=4, RUN_PERIOD=5, NUM_LOAD=4, NUM_VIEW=8, SW_W=32.

1. Reset, then hold `btn_load` high with `sw`=0xDEADBEEF. Slot 0 = 0xDEADBEEF, `load_strobe`=4'b0001 for exactly one cycle at edge 7, and only one pulse is seen while held 40 cycles.
2. Bounce `btn_next` high 3 cycles / low 1 cycle ×5, then hold it high. Exactly one increment occurs, and `load_idx` reaches 1 only after a clean 4-cycle window. Five clean presses give `load_idx` 1,2,3,0,1 (wrap).
3. Press `btn_view` 7 times with `view_data` channel k = 0x1111_1111*k. `disp_data` reads 0x7777_7777 one cycle after `view_idx`=7. One more press gives `view_idx`=0 and `disp_data`=0.
4. Press `btn_run`. `run_mode`=1, and `step_pulse` is high at entry+5, +10, +15. A `btn_step` press during RUN produces no extra pulse. A second `btn_run` press gives `run_mode`=0 with no pulse in the exit cycle.
5. Press `btn_load` and `btn_next` in the same cycle with `load_idx`=2 and `sw`=0xA5A5A5A5. Slot 2 = 0xA5A5A5A5, `load_strobe`=4'b0100, and `load_idx`=3.
6. Assert `rst` in RUN at counter=3 with `btn_step` mid-debounce. All outputs are at their reset values next cycle. No `step_pulse` occurs afterwards until a fresh 4-cycle stable press.

Source files
------------

// File: rtl/board_probe_if.sv
`default_nettype none
// ============================================================================
//  Module      : board_probe_if
//  Description : Panel-side bundle for board_probe_ctrl. Carries the raw board
//                switches and buttons, the DUT observation words, and the
//                cleaned control outputs (slot registers, strobes, step
//                enable, display word, indices, run flag).
//  Modports    : master - board / bench side (drives sw, buttons, view_data)
//                slave  - controller side (drives the control outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
interface board_probe_if #(
    parameter int SW_W     = 32,
    parameter int NUM_LOAD = 4,
    parameter int NUM_VIEW = 8
);
    logic [SW_W-1:0]              sw;
    logic                         btn_next;
    logic                         btn_load;
    logic                         btn_view;
    logic                         btn_step;
    logic                         btn_run;
    logic [NUM_VIEW*32-1:0]       view_data;

    logic [NUM_LOAD*SW_W-1:0]     load_bus;
    logic [NUM_LOAD-1:0]          load_strobe;
    logic                         step_pulse;
    logic [31:0]                  disp_data;
    logic [$clog2(NUM_LOAD)-1:0]  load_idx;
    logic [$clog2(NUM_VIEW)-1:0]  view_idx;
    logic                         run_mode;

    modport master (
        output sw, btn_next, btn_load, btn_view, btn_step, btn_run, view_data,
        input  load_bus, load_strobe, step_pulse, disp_data, load_idx, view_idx, run_mode
    );

    modport slave (
        input  sw, btn_next, btn_load, btn_view, btn_step, btn_run, view_data,
        output load_bus, load_strobe, step_pulse, disp_data, load_idx, view_idx, run_mode
    );
endinterface
`default_nettype wire

// File: rtl/board_probe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_probe_ctrl
//  Description : Front-panel controller. Synchronises and debounces five
//                push-buttons into single-cycle pulses, then uses them to
//                cycle the load slot, write switch values into slots, cycle
//                the display channel and issue DUT step enables (single or
//                free-running).
//  Ports       : clk  - board clock
//                rst  - synchronous active-high reset
//                bus  - board_probe_if.slave: sw, btn_*, view_data in;
//                       load_bus, load_strobe, step_pulse, disp_data,
//                       load_idx, view_idx, run_mode out
//  Revision    : 1.0 - initial release
// ============================================================================
module board_probe_ctrl #(
    parameter int SW_W       = 32,
    parameter int NUM_LOAD   = 4,
    parameter int NUM_VIEW   = 8,
    parameter int DB_CYCLES  = 500000,
    parameter int RUN_PERIOD = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    board_probe_if.slave bus
);
    localparam int c_LIDX_W = $clog2(NUM_LOAD);
    localparam int c_VIDX_W = $clog2(NUM_VIEW);
    localparam int c_DB_W   = $clog2(DB_CYCLES);
    localparam int c_RUN_W  = $clog2(RUN_PERIOD);
    localparam int c_NBTN   = 5;
    localparam int c_B_NEXT = 0;
    localparam int c_B_LOAD = 1;
    localparam int c_B_VIEW = 2;
    localparam int c_B_STEP = 3;
    localparam int c_B_RUN  = 4;

    logic [c_NBTN-1:0] w_raw;
    logic [c_NBTN-1:0] w_pulse;

    assign w_raw = {bus.btn_run, bus.btn_step, bus.btn_view, bus.btn_load, bus.btn_next};

    // ------------------------------------------------------------------
    // Button conditioning: 2-flop sync, counter debounce, rising-edge pulse.
    // The pulse is registered one cycle after the stable level changes.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < c_NBTN; b++) begin : g_btn
        logic              r_sync1;
        logic              r_sync2;
        logic              r_stable;
        logic              r_stable_q;
        logic              r_pulse;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1    <= 1'b0;
                r_sync2    <= 1'b0;
                r_stable   <= 1'b0;
                r_stable_q <= 1'b0;
                r_pulse    <= 1'b0;
                r_cnt      <= '0;
            end else begin
                r_sync1    <= w_raw[b];
                r_sync2    <= r_sync1;
                r_stable_q <= r_stable;
                r_pulse    <= r_stable & ~r_stable_q;
                if (r_sync2 != r_stable) begin
                    // This sample is the DB_CYCLES-th consecutive mismatch.
                    if (r_cnt == c_DB_W'(DB_CYCLES - 1)) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DB_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_pulse[b] = r_pulse;
    end

    // ------------------------------------------------------------------
    // Load slots, indices and display register
    // ------------------------------------------------------------------
    logic [SW_W-1:0]     r_slot [NUM_LOAD];
    logic [NUM_LOAD-1:0] r_strobe;
    logic [c_LIDX_W-1:0] r_load_idx;
    logic [c_VIDX_W-1:0] r_view_idx;
    logic [31:0]         r_disp;
    logic [31:0]         w_view [NUM_VIEW];

    for (genvar v = 0; v < NUM_VIEW; v++) begin : g_view
        assign w_view[v] = bus.view_data[32*v +: 32];
    end

    for (genvar s = 0; s < NUM_LOAD; s++) begin : g_slot
        assign bus.load_bus[SW_W*s +: SW_W] = r_slot[s];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOAD; i++) begin
                r_slot[i] <= '0;
            end
            r_strobe   <= '0;
            r_load_idx <= '0;
            r_view_idx <= '0;
            r_disp     <= '0;
        end else begin
            r_strobe <= '0;
            // Load and next together: the write uses the pre-advance index.
            if (w_pulse[c_B_LOAD]) begin
                r_slot[r_load_idx]   <= bus.sw;
                r_strobe[r_load_idx] <= 1'b1;
            end
            if (w_pulse[c_B_NEXT]) begin
                r_load_idx <= (r_load_idx == c_LIDX_W'(NUM_LOAD - 1)) ? '0
                                                                      : r_load_idx + c_LIDX_W'(1);
            end
            if (w_pulse[c_B_VIEW]) begin
                r_view_idx <= (r_view_idx == c_VIDX_W'(NUM_VIEW - 1)) ? '0
                                                                      : r_view_idx + c_VIDX_W'(1);
            end
            // Sampled every cycle so the display follows live DUT changes.
            r_disp <= w_view[r_view_idx];
        end
    end

    // ------------------------------------------------------------------
    // Step FSM: single step in IDLE, periodic step in RUN
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_RUN_W-1:0] r_run_cnt;
    logic [c_RUN_W-1:0] w_run_cnt_next;
    logic               r_step;
    logic               w_step_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_run_cnt <= '0;
            r_step    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_run_cnt <= w_run_cnt_next;
            r_step    <= w_step_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_run_cnt_next = r_run_cnt;
        w_step_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A step coinciding with run entry is still issued.
                w_step_next = w_pulse[c_B_STEP];
                if (w_pulse[c_B_RUN]) begin
                    w_state_next   = ST_RUN;
                    w_run_cnt_next = '0;
                end
            end
            ST_RUN: begin
                // Leaving RUN suppresses any step due on the same edge.
                if (w_pulse[c_B_RUN]) begin
                    w_state_next   = ST_IDLE;
                    w_run_cnt_next = '0;
                end else if (r_run_cnt == c_RUN_W'(RUN_PERIOD - 1)) begin
                    w_step_next    = 1'b1;
                    w_run_cnt_next = '0;
                end else begin
                    w_run_cnt_next = r_run_cnt + c_RUN_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.load_strobe = r_strobe;
    assign bus.step_pulse  = r_step;
    assign bus.disp_data   = r_disp;
    assign bus.load_idx    = r_load_idx;
    assign bus.view_idx    = r_view_idx;
    assign bus.run_mode    = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_board_probe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_probe_ctrl
//  Description : Self-checking bench for board_probe_ctrl. A behavioural
//                reference model (sliding-window debounce, event-level panel
//                behaviour) runs alongside the DUT; scenario tasks add
//                directed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_probe_ctrl;
    localparam int SW_W = 32;
    localparam int NL   = 4;
    localparam int NV   = 8;
    localparam int DB   = 4;
    localparam int RP   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    board_probe_if #(.SW_W(SW_W), .NUM_LOAD(NL), .NUM_VIEW(NV)) bus ();

    board_probe_ctrl #(
        .SW_W(SW_W), .NUM_LOAD(NL), .NUM_VIEW(NV), .DB_CYCLES(DB), .RUN_PERIOD(RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. A button's clean level flips once the last DB
    // samples seen through the two-stage synchroniser all disagree with
    // it; the effect lands two edges after the flip.
    // ------------------------------------------------------------------
    logic [DB+1:0]  m_hist [5];
    logic [4:0]     m_stable, m_p1, m_p2;
    logic [31:0]    m_slot [NL];
    logic [NL-1:0]  m_strobe;
    int             m_lidx, m_vidx, m_phase;
    logic           m_run, m_step;
    logic [31:0]    m_disp;

    always @(posedge clk) begin : ref_model
        logic [DB+1:0] h [5];
        logic [4:0]    st, p1, p2, due, raw;
        logic [31:0]   slot [NL];
        logic [NL-1:0] strobe;
        int            lidx, vidx, phase;
        logic          run, step;
        logic [31:0]   disp;
        raw = {bus.btn_run, bus.btn_step, bus.btn_view, bus.btn_load, bus.btn_next};
        h = m_hist; st = m_stable; p1 = m_p1; p2 = m_p2; slot = m_slot;
        strobe = m_strobe; lidx = m_lidx; vidx = m_vidx; phase = m_phase;
        run = m_run; step = m_step; disp = m_disp;
        if (rst) begin
            for (int b = 0; b < 5; b++) h[b] = '0;
            for (int s = 0; s < NL; s++) slot[s] = '0;
            st = '0; p1 = '0; p2 = '0; strobe = '0;
            lidx = 0; vidx = 0; phase = 0; run = 1'b0; step = 1'b0; disp = '0;
        end else begin
            due = p2; p2 = p1; p1 = '0;
            for (int b = 0; b < 5; b++) begin
                h[b] = {h[b][DB:0], raw[b]};
                if (h[b][DB+1:2] == {DB{~st[b]}}) begin
                    st[b] = ~st[b];
                    p1[b] = st[b];
                end
            end
            strobe = '0;
            if (due[1]) begin slot[lidx] = bus.sw; strobe[lidx] = 1'b1; end
            if (due[0]) lidx = (lidx + 1) % NL;
            disp = bus.view_data[vidx*32 +: 32];
            if (due[2]) vidx = (vidx + 1) % NV;
            step = 1'b0;
            if (run) begin
                if (due[4]) run = 1'b0;
                else begin
                    phase++;
                    if (phase == RP) begin step = 1'b1; phase = 0; end
                end
            end else begin
                if (due[3]) step = 1'b1;
                if (due[4]) begin run = 1'b1; phase = 0; end
            end
        end
        m_hist <= h; m_stable <= st; m_p1 <= p1; m_p2 <= p2; m_slot <= slot;
        m_strobe <= strobe; m_lidx <= lidx; m_vidx <= vidx; m_phase <= phase;
        m_run <= run; m_step <= step; m_disp <= disp;
    end

    function automatic logic [NL*SW_W-1:0] exp_bus();
        logic [NL*SW_W-1:0] r;
        for (int s = 0; s < NL; s++) r[s*SW_W +: SW_W] = m_slot[s];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.sw = '0; bus.view_data = '0;
        bus.btn_next = 1'b0; bus.btn_load = 1'b0; bus.btn_view = 1'b0;
        bus.btn_step = 1'b0; bus.btn_run = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic press_next();
        bus.btn_next = 1'b1; repeat (8) tick();
        bus.btn_next = 1'b0; repeat (8) tick();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        bus.sw = $urandom; bus.view_data = {8{$urandom}};
        bus.btn_next = 1'b1; bus.btn_load = 1'b1; bus.btn_view = 1'b1;
        bus.btn_step = 1'b1; bus.btn_run = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.load_bus !== '0) begin n_bad++; $display("FAIL reset load_bus: got %h want 0", bus.load_bus); end
        n_cmp++; if (bus.load_strobe !== 4'b0) begin n_bad++; $display("FAIL reset load_strobe: got %b want 0000", bus.load_strobe); end
        n_cmp++; if (bus.step_pulse !== 1'b0) begin n_bad++; $display("FAIL reset step_pulse: got %b want 0", bus.step_pulse); end
        n_cmp++; if (bus.disp_data !== 32'h0) begin n_bad++; $display("FAIL reset disp_data: got %h want 0", bus.disp_data); end
        n_cmp++; if (bus.load_idx !== 2'd0) begin n_bad++; $display("FAIL reset load_idx: got %0d want 0", bus.load_idx); end
        n_cmp++; if (bus.view_idx !== 3'd0) begin n_bad++; $display("FAIL reset view_idx: got %0d want 0", bus.view_idx); end
        n_cmp++; if (bus.run_mode !== 1'b0) begin n_bad++; $display("FAIL reset run_mode: got %b want 0", bus.run_mode); end
        clear_inputs();
    endtask

    task automatic test_load_hold();
        int pulses = 0;
        do_reset();
        bus.sw = 32'hDEADBEEF; bus.btn_load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.load_strobe != 4'b0) pulses++;
            n_cmp++; if (bus.load_strobe !== ((i == 7) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL load_hold strobe edge %0d: got %b want %b", i, bus.load_strobe, (i == 7) ? 4'b0001 : 4'b0000); end
            n_cmp++; if (bus.load_strobe !== m_strobe) begin n_bad++; $display("FAIL load_hold strobe_model edge %0d: got %b want %b", i, bus.load_strobe, m_strobe); end
            if (i == 7) begin
                n_cmp++; if (bus.load_bus[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_hold slot0: got %h want deadbeef", bus.load_bus[31:0]); end
            end
            if (i == 10) bus.sw = $urandom;
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL load_hold pulse_count: got %0d want 1", pulses); end
        n_cmp++; if (bus.load_bus !== exp_bus()) begin n_bad++; $display("FAIL load_hold bus: got %h want %h", bus.load_bus, exp_bus()); end
        bus.btn_load = 1'b0; repeat (8) tick();
    endtask

    task automatic test_debounce_next();
        int exp_l [5] = '{1, 2, 3, 0, 1};
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bus.btn_next = ((c % 4) != 3);
            tick();
            n_cmp++; if (bus.load_idx !== 2'd0) begin n_bad++; $display("FAIL bounce load_idx cycle %0d: got %0d want 0", c, bus.load_idx); end
        end
        bus.btn_next = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++; if (bus.load_idx !== ((i >= 7) ? 2'd1 : 2'd0)) begin n_bad++; $display("FAIL bounce_hold load_idx edge %0d: got %0d want %0d", i, bus.load_idx, (i >= 7) ? 1 : 0); end
            n_cmp++; if (bus.load_idx !== 2'(m_lidx)) begin n_bad++; $display("FAIL bounce_hold load_idx_model edge %0d: got %0d want %0d", i, bus.load_idx, m_lidx); end
        end
        bus.btn_next = 1'b0; repeat (8) tick();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            press_next();
            n_cmp++; if (bus.load_idx !== 2'(exp_l[p])) begin n_bad++; $display("FAIL next_wrap press %0d: got %0d want %0d", p, bus.load_idx, exp_l[p]); end
        end
    endtask

    task automatic test_view();
        logic [31:0] v;
        do_reset();
        for (int k = 0; k < NV; k++) bus.view_data[32*k +: 32] = 32'(32'h11111111 * k);
        for (int p = 0; p < 7; p++) begin
            bus.btn_view = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (p == 6 && i == 7) begin
                    n_cmp++; if (bus.view_idx !== 3'd7) begin n_bad++; $display("FAIL view idx7: got %0d want 7", bus.view_idx); end
                    n_cmp++; if (bus.disp_data !== 32'h66666666) begin n_bad++; $display("FAIL view lag: got %h want 66666666", bus.disp_data); end
                end
            end
            bus.btn_view = 1'b0;
            tick();
            if (p == 6) begin
                n_cmp++; if (bus.disp_data !== 32'h77777777) begin n_bad++; $display("FAIL view disp7: got %h want 77777777", bus.disp_data); end
            end
            repeat (7) tick();
        end
        bus.btn_view = 1'b1; repeat (8) tick();
        bus.btn_view = 1'b0; repeat (8) tick();
        n_cmp++; if (bus.view_idx !== 3'd0) begin n_bad++; $display("FAIL view wrap idx: got %0d want 0", bus.view_idx); end
        n_cmp++; if (bus.disp_data !== 32'h0) begin n_bad++; $display("FAIL view wrap disp: got %h want 0", bus.disp_data); end
        v = $urandom | 32'h1;
        bus.view_data[31:0] = v;
        tick();
        n_cmp++; if (bus.disp_data !== v) begin n_bad++; $display("FAIL view live: got %h want %h", bus.disp_data, v); end
        n_cmp++; if (bus.disp_data !== m_disp) begin n_bad++; $display("FAIL view live_model: got %h want %h", bus.disp_data, m_disp); end
    endtask

    task automatic test_run();
        logic exp_run, exp_step;
        do_reset();
        bus.btn_run = 1'b1;
        for (int i = 0; i < 46; i++) begin
            tick();
            exp_run  = (i >= 7 && i < 37);
            exp_step = (i >= 12 && i < 37 && ((i - 7) % 5) == 0);
            n_cmp++; if (bus.run_mode !== exp_run) begin n_bad++; $display("FAIL run run_mode edge %0d: got %b want %b", i, bus.run_mode, exp_run); end
            n_cmp++; if (bus.step_pulse !== exp_step) begin n_bad++; $display("FAIL run step_pulse edge %0d: got %b want %b", i, bus.step_pulse, exp_step); end
            n_cmp++; if (bus.step_pulse !== m_step) begin n_bad++; $display("FAIL run step_model edge %0d: got %b want %b", i, bus.step_pulse, m_step); end
            bus.btn_run  = ((i + 1) < 8) || ((i + 1) >= 30 && (i + 1) < 38);
            bus.btn_step = ((i + 1) >= 13 && (i + 1) < 21);
        end
        clear_inputs(); repeat (8) tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        press_next(); press_next();
        bus.sw = 32'hA5A5A5A5; bus.btn_load = 1'b1; bus.btn_next = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 7) begin
                n_cmp++; if (bus.load_bus[95:64] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL b2b slot2: got %h want a5a5a5a5", bus.load_bus[95:64]); end
                n_cmp++; if (bus.load_strobe !== 4'b0100) begin n_bad++; $display("FAIL b2b strobe: got %b want 0100", bus.load_strobe); end
                n_cmp++; if (bus.load_idx !== 2'd3) begin n_bad++; $display("FAIL b2b load_idx: got %0d want 3", bus.load_idx); end
            end
        end
        n_cmp++; if (bus.load_bus !== exp_bus()) begin n_bad++; $display("FAIL b2b bus_model: got %h want %h", bus.load_bus, exp_bus()); end
        clear_inputs(); repeat (8) tick();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        bus.view_data[31:0] = $urandom | 32'h1;
        bus.btn_run = 1'b1;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (i == 10) begin
                n_cmp++; if (bus.run_mode !== 1'b1) begin n_bad++; $display("FAIL rst_mid pre run_mode: got %b want 1", bus.run_mode); end
            end
            if (i == 11) begin
                n_cmp++; if (bus.run_mode !== 1'b0) begin n_bad++; $display("FAIL rst_mid run_mode: got %b want 0", bus.run_mode); end
                n_cmp++; if (bus.disp_data !== 32'h0) begin n_bad++; $display("FAIL rst_mid disp_data: got %h want 0", bus.disp_data); end
                n_cmp++; if (bus.load_idx !== 2'd0 || bus.view_idx !== 3'd0) begin n_bad++; $display("FAIL rst_mid idx: got %0d/%0d want 0/0", bus.load_idx, bus.view_idx); end
                n_cmp++; if (bus.load_strobe !== 4'b0 || bus.load_bus !== '0) begin n_bad++; $display("FAIL rst_mid load: got %b/%h want 0", bus.load_strobe, bus.load_bus); end
            end
            n_cmp++; if (bus.step_pulse !== (i == 19)) begin n_bad++; $display("FAIL rst_mid step_pulse edge %0d: got %b want %b", i, bus.step_pulse, i == 19); end
            bus.btn_run  = ((i + 1) < 8);
            bus.btn_step = ((i + 1) >= 8);
            rst          = ((i + 1) == 11);
        end
        rst = 1'b0;
        clear_inputs(); repeat (8) tick();
    endtask

    task automatic test_random();
        int hold [5];
        logic [4:0] lvl;
        do_reset();
        lvl = '0;
        for (int b = 0; b < 5; b++) hold[b] = $urandom_range(1, 12);
        for (int c = 0; c < 800; c++) begin
            tick();
            n_cmp++; if (bus.load_bus !== exp_bus()) begin n_bad++; $display("FAIL rand load_bus cycle %0d: got %h want %h", c, bus.load_bus, exp_bus()); end
            n_cmp++; if (bus.load_strobe !== m_strobe) begin n_bad++; $display("FAIL rand strobe cycle %0d: got %b want %b", c, bus.load_strobe, m_strobe); end
            n_cmp++; if (bus.step_pulse !== m_step) begin n_bad++; $display("FAIL rand step cycle %0d: got %b want %b", c, bus.step_pulse, m_step); end
            n_cmp++; if (bus.disp_data !== m_disp) begin n_bad++; $display("FAIL rand disp cycle %0d: got %h want %h", c, bus.disp_data, m_disp); end
            n_cmp++; if (bus.load_idx !== 2'(m_lidx)) begin n_bad++; $display("FAIL rand load_idx cycle %0d: got %0d want %0d", c, bus.load_idx, m_lidx); end
            n_cmp++; if (bus.view_idx !== 3'(m_vidx)) begin n_bad++; $display("FAIL rand view_idx cycle %0d: got %0d want %0d", c, bus.view_idx, m_vidx); end
            n_cmp++; if (bus.run_mode !== m_run) begin n_bad++; $display("FAIL rand run_mode cycle %0d: got %b want %b", c, bus.run_mode, m_run); end
            for (int b = 0; b < 5; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin lvl[b] = ~lvl[b]; hold[b] = $urandom_range(1, 12); end
            end
            {bus.btn_run, bus.btn_step, bus.btn_view, bus.btn_load, bus.btn_next} = lvl;
            bus.sw = $urandom;
            bus.view_data[32*$urandom_range(0, NV-1) +: 32] = $urandom;
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        clear_inputs(); repeat (8) tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_hold();
        test_debounce_next();
        test_view();
        test_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
